// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, samples the synchronized
// columns once per row dwell, and debounces whole-matrix scan results into a key code.
module keypad_scan_decoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]       col_s1_q, col_s1_d, col_s2_q, col_s2_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic             acc_hit_q, acc_hit_d;
    logic [3:0]       acc_code_q, acc_code_d;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic       tick, scan_end, row_hit, scan_hit, accept, release_done;
    logic [1:0] col_idx;
    logic [3:0] row_code, scan_code;

    // 2-to-4 decoder for the active-low row strobe
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row[gi] = (row_idx_q != 2'(gi));
        end
    endgenerate

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    always_comb begin
        col_s1_d  = col;
        col_s2_d  = col_s1_q;
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        row_idx_d = tick ? row_idx_q + 2'd1 : row_idx_q;
        scan_end  = tick && (row_idx_q == 2'd3);

        row_hit = ~&col_s2_q;
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s2_q[i]) col_idx = 2'(i);
        end
        row_code = {row_idx_q, col_idx};

        // Rows are visited in ascending order, so the first hit of a scan is the lowest code.
        scan_hit  = acc_hit_q || row_hit;
        scan_code = acc_hit_q ? acc_code_q : row_code;

        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (scan_end) begin
            acc_hit_d  = 1'b0;
            acc_code_d = 4'h0;
        end else if (tick && row_hit && !acc_hit_q) begin
            acc_hit_d  = 1'b1;
            acc_code_d = row_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            div_cnt_q  <= '0;
            row_idx_q  <= 2'd0;
            acc_hit_q  <= 1'b0;
            acc_code_q <= 4'h0;
        end else begin
            col_s1_q   <= col_s1_d;
            col_s2_q   <= col_s2_d;
            div_cnt_q  <= div_cnt_d;
            row_idx_q  <= row_idx_d;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (scan_hit) state_d = (DEBOUNCE_SCANS == 1) ? PRESSED : DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!scan_hit) state_d = IDLE;
                    else if (scan_code == cand_q && deb_cnt_q == DEB_LAST) state_d = PRESSED;
                end
                PRESSED: begin
                    if (!scan_hit || scan_code != key_code_q)
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                end
                RELEASE: begin
                    if (scan_hit && scan_code == key_code_q) state_d = PRESSED;
                    else if (deb_cnt_q == DEB_LAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cand_d       = cand_q;
        deb_cnt_d    = deb_cnt_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;
        accept       = (state_q == IDLE || state_q == DEBOUNCE) && state_d == PRESSED;
        release_done = (state_q == PRESSED || state_q == RELEASE) && state_d == IDLE;

        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (scan_hit) begin
                        cand_d    = scan_code;
                        deb_cnt_d = DEB_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!scan_hit) begin
                        deb_cnt_d = '0;
                    end else if (scan_code == cand_q) begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end else begin
                        cand_d    = scan_code;
                        deb_cnt_d = DEB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!scan_hit || scan_code != key_code_q) deb_cnt_d = DEB_W'(1);
                end
                RELEASE: begin
                    if (!(scan_hit && scan_code == key_code_q))
                        deb_cnt_d = (deb_cnt_q == DEB_LAST) ? '0 : deb_cnt_q + 1'b1;
                end
                default: deb_cnt_d = '0;
            endcase
        end

        // key_code only moves on accept; it is held through release and idle.
        if (accept) begin
            key_code_d  = scan_code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
        end
        if (release_done) key_held_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q      <= 4'h0;
            deb_cnt_q   <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule
